// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial W-bit subtractor (a - b - bin) through one shared
// full-subtractor cell, LSB first, with valid/ready handshakes on both sides.
module serial_sub_ctrl #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] diff,
  output logic         bout,
  output logic         zero,
  output logic         ovf
);
  localparam int CW = $clog2(W);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t r_state, w_next;
  logic [W-1:0] r_a, r_b, r_diff;
  logic [CW-1:0] r_cnt;
  logic r_br, r_bout, r_zero, r_ovf;
  logic w_d, w_br, w_last, w_accept;
  logic [W-1:0] w_diff_next;
  assign w_d = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br = (~r_a[0] & r_b[0]) | (~r_a[0] & r_br) | (r_b[0] & r_br);
  assign w_last = r_cnt == CW'(W - 1);
  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_diff_next = {w_d, r_diff[W-1:1]};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = RUN;
      end
      RUN: if (w_last) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end
  // Flags are captured on the last RUN edge; r_br then holds the borrow into bit W-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a <= '0;
      r_b <= '0;
      r_diff <= '0;
      r_cnt <= '0;
      r_br <= 1'b0;
      r_bout <= 1'b0;
      r_zero <= 1'b0;
      r_ovf <= 1'b0;
    end else if (w_accept) begin
      r_a <= a;
      r_b <= b;
      r_br <= bin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a <= r_a >> 1;
      r_b <= r_b >> 1;
      r_br <= w_br;
      r_diff <= w_diff_next;
      if (w_last) begin
        r_bout <= w_br;
        r_ovf <= r_br ^ w_br;
        r_zero <= w_diff_next == '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end
  assign diff = r_diff;
  assign bout = r_bout;
  assign zero = r_zero;
  assign ovf = r_ovf;
endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: randomized check of serial_sub_ctrl (W=8 and W=2)
// against an arithmetic reference model.
module tb_serial_sub_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid, in_ready, bin, out_valid, out_ready, bout, zero, ovf;
  logic [7:0] a, b, diff;
  logic in_valid2, in_ready2, bin2, out_valid2, out_ready2, bout2, zero2, ovf2;
  logic [1:0] a2, b2, diff2;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  serial_sub_ctrl #(.W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .bout(bout), .zero(zero), .ovf(ovf)
  );
  serial_sub_ctrl #(.W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .a(a2), .b(b2), .bin(bin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .diff(diff2), .bout(bout2), .zero(zero2), .ovf(ovf2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic run8(input logic [7:0] ta, input logic [7:0] tb_, input logic tbin, input int stall);
    int ra, rb, sa, sb, rs, lat;
    logic [7:0] ed;
    logic eb, ez, eo;
    ra = int'(ta);
    rb = int'(tb_);
    sa = ra > 127 ? ra - 256 : ra;
    sb = rb > 127 ? rb - 256 : rb;
    ed = 8'((ra - rb - int'(tbin)) & 255);
    eb = ra < rb + int'(tbin);
    rs = sa - sb - int'(tbin);
    eo = rs < -128 || rs > 127;
    ez = ed == 8'h00;
    @(negedge clk);
    a = ta; b = tb_; bin = tbin; in_valid = 1'b1; out_ready = 1'b0;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; a = 8'($urandom); b = 8'($urandom); bin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      out_ready = 1'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    out_ready = 1'b0;
    chk("latency", 32'(lat), 32'd8);
    chk("diff", 32'(diff), 32'(ed));
    chk("bout", 32'(bout), 32'(eb));
    chk("zero", 32'(zero), 32'(ez));
    chk("ovf", 32'(ovf), 32'(eo));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_res", {22'd0, ovf, zero, bout, diff}, {22'd0, eo, ez, eb, ed});
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("post_hs_valid", 32'(out_valid), 32'd0);
    chk("post_hs_ready", 32'(in_ready), 32'd1);
  endtask
  task automatic run2(input logic [1:0] ta, input logic [1:0] tb_, input logic tbin);
    int lat, st;
    logic [2:0] exp3;
    exp3 = 3'((int'(ta) - int'(tb_) - int'(tbin)) & 7);
    @(negedge clk);
    a2 = ta; b2 = tb_; bin2 = tbin; in_valid2 = 1'b1; out_ready2 = 1'b0;
    @(posedge clk);
    #1;
    in_valid2 = 1'b0; a2 = 2'($urandom); b2 = 2'($urandom);
    lat = 0;
    while (!out_valid2 && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("w2_latency", 32'(lat), 32'd2);
    st = $urandom_range(0, 3);
    repeat (st) @(negedge clk);
    chk("w2_result", {29'd0, bout2, diff2}, {29'd0, exp3});
    @(negedge clk);
    out_ready2 = 1'b1;
    @(posedge clk);
    #1;
    out_ready2 = 1'b0;
    chk("w2_post_hs", 32'(out_valid2), 32'd0);
  endtask
  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    in_valid2 = 1'b0; out_ready2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_flags", {28'd0, ovf, zero, bout, 1'b0}, 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h05, 8'h03, 1'b0, 0);
    run8(8'h03, 8'h05, 1'b0, 1);
    run8(8'h00, 8'h00, 1'b1, 0);
    run8(8'h80, 8'h01, 1'b0, 2);
    run8(8'h10, 8'h10, 1'b0, 0);
    run8(8'h7F, 8'hFF, 1'b0, 5);
    run8(8'hC3, 8'h5A, 1'b1, 5);
    for (int i = 0; i < 20; i++)
      run8(8'($urandom), 8'($urandom), 1'($urandom), $urandom_range(0, 3));
    @(negedge clk);
    a = 8'hFF; b = 8'h00; bin = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_diff", 32'(diff), 32'd0);
    chk("mid_rst_flags", {29'd0, ovf, zero, bout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run8(8'h5A, 8'h3C, 1'b1, 1);
    for (int i = 0; i < 32; i++) begin
      logic [4:0] v;
      v = 5'(i);
      run2(v[1:0], v[3:2], v[4]);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
